alu_pipe: RTL

Parametrised two-stage pipelined integer ALU for the execute stage. It supports XLEN 32 or 64 with RV64 word ops, and adds min/max and rotate operations to the existing add/sub/logic/shift/set-on-condition set. Upstream issue and downstream writeback connect through valid/ready handshakes. A flush drops every in-flight operation.

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_if.sv | 34 +++
 rtl/alu_shifter.sv | 59 +++++
 rtl/alu_pipe.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the pipelined integer ALU.
// Holds the operation and condition-code encodings and the control word carried from
// stage 1 to stage 2.
package alu_pkg;

  typedef enum logic [3:0] {
    OpAdd  = 4'd0,
    OpSub  = 4'd1,
    OpAnd  = 4'd2,
    OpOr   = 4'd3,
    OpXor  = 4'd4,
    OpSll  = 4'd5,
    OpSrl  = 4'd6,
    OpSra  = 4'd7,
    OpRol  = 4'd8,
    OpRor  = 4'd9,
    OpScc  = 4'd10,
    OpMin  = 4'd11,
    OpMax  = 4'd12,
    OpMinu = 4'd13,
    OpMaxu = 4'd14
  } alu_op_e;

  // Bits [2:1] pick the flag (FALSE/EQ/LT/LTU) and bit 0 inverts it.
  typedef enum logic [2:0] {
    CcFalse = 3'd0,
    CcTrue  = 3'd1,
    CcEq    = 3'd2,
    CcNe    = 3'd3,
    CcLt    = 3'd4,
    CcGe    = 3'd5,
    CcLtu   = 3'd6,
    CcGeu   = 3'd7
  } condition_code_e;

  // Control and precomputed flags registered in stage 1.
  typedef struct packed {
    alu_op_e         op;
    condition_code_e cc;
    logic            word;
    logic            eq;
    logic            lt;
    logic            ltu;
  } s1_ctrl_t;

endpackage

// File: rtl/alu_if.sv
// Issue and writeback handshake bundle of the ALU pipeline.
// master: the issuing/consuming side; slave: the ALU.
//   in_*  : operation channel (valid/ready), op, cc, word, operands, tag
//   out_* : result channel (valid/ready), result, tag
interface alu_if import alu_pkg::*; #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 6
) ();

  logic             in_valid;
  logic             in_ready;
  alu_op_e          in_op;
  condition_code_e  in_cc;
  logic             in_word;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_cc, in_word, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_cc, in_word, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );

endinterface

// File: rtl/alu_shifter.sv
// Shift/rotate unit: one right shifter; left shifts and rotates reverse the operand going in
// and the result coming out.
//   a_i      : operand
//   amt_i    : shift amount (already masked to 5 or 6 bits by the caller)
//   word_i   : operate on a_i[31:0] only (upper result bits are don't-care)
//   op_i     : OpSll/OpSrl/OpSra/OpRol/OpRor; other ops give a don't-care result
//   result_o : shifted value
module alu_shifter import alu_pkg::*; #(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [5:0]      amt_i,
  input  logic            word_i,
  input  alu_op_e         op_i,
  output logic [XLEN-1:0] result_o
);

  logic              left;
  logic              rot;
  logic              arith;
  logic [XLEN-1:0]   body;
  logic [2*XLEN-1:0] ext;
  logic [XLEN-1:0]   shifted;

  always_comb begin
    left  = (op_i == OpSll) || (op_i == OpRol);
    rot   = (op_i == OpRol) || (op_i == OpRor);
    arith = (op_i == OpSra);

    body = a_i;
    if (word_i) begin
      body = '0;
      for (int i = 0; i < 32; i++) body[i] = left ? a_i[31-i] : a_i[i];
    end else if (left) begin
      for (int i = 0; i < XLEN; i++) body[i] = a_i[XLEN-1-i];
    end

    // Upper half is what shifts in: a copy of the operand for rotates, else the fill bit.
    ext = '0;
    if (word_i) begin
      ext[63:0] = {(rot ? body[31:0] : {32{arith & a_i[31]}}), body[31:0]};
    end else begin
      ext = {(rot ? body : {XLEN{arith & a_i[XLEN-1]}}), body};
    end

    shifted = XLEN'(ext >> amt_i);

    result_o = shifted;
    if (left) begin
      result_o = '0;
      if (word_i) begin
        for (int i = 0; i < 32; i++) result_o[i] = shifted[31-i];
      end else begin
        for (int i = 0; i < XLEN; i++) result_o[i] = shifted[XLEN-1-i];
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined integer ALU with valid/ready on both sides.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   flush_i : drop every in-flight op and any op offered this cycle
//   io      : alu_if slave (issue channel in_*, writeback channel out_*)
// Stage 1 registers the operands plus sum, difference and EQ/LT/LTU flags; stage 2 selects
// and word-extends the result into the output register.
module alu_pipe import alu_pkg::*; #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 6
) (
  input logic  clk_i,
  input logic  rst_ni,
  input logic  flush_i,
  alu_if.slave io
);

  localparam bit HasWord = (XLEN == 64);

  logic             s1_valid_q, s1_valid_d;
  logic             s2_valid_q, s2_valid_d;
  logic             s2_ready, s1_advance, in_ready, accept;

  s1_ctrl_t         s1_ctrl_q, s1_ctrl_d;
  logic [XLEN-1:0]  s1_a_q, s1_b_q;
  logic [XLEN-1:0]  s1_sum_q, s1_sum_d;
  logic [XLEN-1:0]  s1_diff_q, s1_diff_d;
  logic [TAG_W-1:0] s1_tag_q;

  logic [XLEN-1:0]  s2_result_q, s2_result_d;
  logic [TAG_W-1:0] s2_tag_q;

  logic             word, a_msb, b_msb, d_msb, eq;
  logic [2:0]       cc_bits;
  logic             flag;
  logic [5:0]       shamt;
  logic [XLEN-1:0]  shift_res, raw;

  // Handshake: in_ready looks through to out_ready so a full pipe can shift in one cycle.
  always_comb begin
    s2_ready   = !s2_valid_q || io.out_ready;
    s1_advance = s1_valid_q && s2_ready;
    in_ready   = !s1_valid_q || s1_advance;
    accept     = io.in_valid && in_ready && !flush_i;

    s1_valid_d = s1_valid_q;
    if (accept)          s1_valid_d = 1'b1;
    else if (s1_advance) s1_valid_d = 1'b0;

    s2_valid_d = s2_valid_q;
    if (s1_advance)       s2_valid_d = 1'b1;
    else if (io.out_ready) s2_valid_d = 1'b0;

    if (flush_i) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  // Stage 1: arithmetic and flags. Word ops look only at bit 31 of the 32-bit operands.
  always_comb begin
    word      = HasWord & io.in_word;
    s1_sum_d  = io.in_a + io.in_b;
    s1_diff_d = io.in_a - io.in_b;
    if (word) begin
      a_msb = io.in_a[31];
      b_msb = io.in_b[31];
      d_msb = s1_diff_d[31];
      eq    = (io.in_a[31:0] == io.in_b[31:0]);
    end else begin
      a_msb = io.in_a[XLEN-1];
      b_msb = io.in_b[XLEN-1];
      d_msb = s1_diff_d[XLEN-1];
      eq    = (io.in_a == io.in_b);
    end
    s1_ctrl_d.op   = io.in_op;
    s1_ctrl_d.cc   = io.in_cc;
    s1_ctrl_d.word = word;
    s1_ctrl_d.eq   = eq;
    // Differing MSBs cannot overflow-compare via the difference; the sign alone decides.
    s1_ctrl_d.lt   = (a_msb == b_msb) ? d_msb : a_msb;
    s1_ctrl_d.ltu  = (a_msb == b_msb) ? d_msb : b_msb;
  end

  assign shamt = (s1_ctrl_q.word || !HasWord) ? {1'b0, s1_b_q[4:0]} : s1_b_q[5:0];

  alu_shifter #(.XLEN(XLEN)) u_shifter (
    .a_i      (s1_a_q),
    .amt_i    (shamt),
    .word_i   (s1_ctrl_q.word),
    .op_i     (s1_ctrl_q.op),
    .result_o (shift_res)
  );

  // Stage 2: result select and word sign extension.
  always_comb begin
    cc_bits = s1_ctrl_q.cc;
    flag    = 1'b0;
    unique case (cc_bits[2:1])
      2'd0: flag = 1'b0;
      2'd1: flag = s1_ctrl_q.eq;
      2'd2: flag = s1_ctrl_q.lt;
      2'd3: flag = s1_ctrl_q.ltu;
      default: flag = 1'b0;
    endcase
    flag = flag ^ cc_bits[0];

    raw = '0;
    case (s1_ctrl_q.op)
      OpAdd:  raw = s1_sum_q;
      OpSub:  raw = s1_diff_q;
      OpAnd:  raw = s1_a_q & s1_b_q;
      OpOr:   raw = s1_a_q | s1_b_q;
      OpXor:  raw = s1_a_q ^ s1_b_q;
      OpSll, OpSrl, OpSra, OpRol, OpRor: raw = shift_res;
      OpScc:  raw[0] = flag;
      OpMin:  raw = (s1_ctrl_q.lt || s1_ctrl_q.eq) ? s1_a_q : s1_b_q;
      OpMax:  raw = s1_ctrl_q.lt ? s1_b_q : s1_a_q;
      OpMinu: raw = (s1_ctrl_q.ltu || s1_ctrl_q.eq) ? s1_a_q : s1_b_q;
      OpMaxu: raw = s1_ctrl_q.ltu ? s1_b_q : s1_a_q;
      default: raw = '0;
    endcase

    s2_result_d = raw;
    if (s1_ctrl_q.word) begin
      for (int i = 32; i < XLEN; i++) s2_result_d[i] = raw[31];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s1_ctrl_q   <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_sum_q    <= '0;
      s1_diff_q   <= '0;
      s1_tag_q    <= '0;
      s2_result_q <= '0;
      s2_tag_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (accept) begin
        s1_ctrl_q <= s1_ctrl_d;
        s1_a_q    <= io.in_a;
        s1_b_q    <= io.in_b;
        s1_sum_q  <= s1_sum_d;
        s1_diff_q <= s1_diff_d;
        s1_tag_q  <= io.in_tag;
      end
      if (s1_advance) begin
        s2_result_q <= s2_result_d;
        s2_tag_q    <= s1_tag_q;
      end
    end
  end

  assign io.in_ready   = in_ready;
  assign io.out_valid  = s2_valid_q;
  assign io.out_result = s2_result_q;
  assign io.out_tag    = s2_tag_q;

endmodule
